// File: rtl/fsm_chk_pkg.sv
// Shared types and constants for the FSM vector checker and its error log.
package fsm_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_HALT
    } chk_state_e;

    localparam int LOG_W = 16;
    localparam int IDX_W = 8;
    localparam int EXP_W = 4;
    localparam int OUT_W = 4;
    localparam int IN_W  = 3;
    localparam int CS_W  = 3;

    localparam logic [2:0] MAX_LEGAL = 3'd4;

    function automatic logic [LOG_W-1:0] make_entry(
        input logic [IDX_W-1:0] idx,
        input logic [EXP_W-1:0] exp_val,
        input logic [OUT_W-1:0] dut_val
    );
        return {idx, exp_val, dut_val};
    endfunction

endpackage

// File: rtl/fsm_chk_log_fifo.sv
// Error-log FIFO: first-word-fall-through head, synchronous flush, push accepted
// when full only if a pop happens in the same cycle. DEPTH must be a power of two >= 2.
module fsm_chk_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fsm_vector_checker.sv
// Checks a stream of (state, input, expected, actual) Mealy vectors and logs failures.
// Define FSM_CHK_STOP_ON_ERR_EN to halt the run on the first failing vector.
module fsm_vector_checker
    import fsm_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 25,
    parameter int LOG_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [IN_W-1:0]  in,
    input  logic [CS_W-1:0]  cs,
    input  logic [EXP_W-1:0] exp_out,
    input  logic [OUT_W-1:0] dut_out,
    output logic             mismatch,
    output logic [15:0]      vec_cnt,
    output logic [7:0]       err_cnt,
    output logic             done,
    output logic             pass,
    input  logic             log_rd,
    output logic             log_valid,
    output logic [LOG_W-1:0] log_data,
    output logic             log_ovf
);

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    chk_state_e       state_q, state_d;
    logic [15:0]      vec_cnt_q, vec_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             fail_q, fail_d;
    logic             ovf_q, ovf_d;
    logic             accept, vec_fail, last_vec, clear_run;
    logic             log_push, log_pop, log_full, log_empty;
    logic [LOG_W-1:0] log_head, log_entry;

    assign vec_ready = (state_q == ST_RUN);
    assign accept    = vec_ready && vec_valid;
    assign vec_fail  = (dut_out != exp_out) || (cs > MAX_LEGAL) || (in > MAX_LEGAL);
    assign last_vec  = (vec_cnt_q == LAST_IDX);
    assign log_push  = accept && vec_fail;
    assign log_pop   = log_rd && !log_empty;
    assign log_entry = make_entry(vec_cnt_q[IDX_W-1:0], exp_out, dut_out);

    always_comb begin
        state_d   = state_q;
        clear_run = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clear_run = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
`ifdef FSM_CHK_STOP_ON_ERR_EN
                    if (vec_fail)      state_d = ST_HALT;
                    else if (last_vec) state_d = ST_DONE;
`else
                    if (last_vec)      state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clear_run = 1'b1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result of a vector is registered on its acceptance edge, so mismatch,
    // err_cnt and the log all show it in the following cycle.
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        fail_d    = 1'b0;
        ovf_d     = ovf_q;
        if (clear_run) begin
            vec_cnt_d = '0;
            err_cnt_d = '0;
            ovf_d     = 1'b0;
        end else if (accept) begin
            if (vec_cnt_q != '1) vec_cnt_d = vec_cnt_q + 16'd1;
            if (vec_fail) begin
                fail_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 8'd1;
                if (log_full && !log_pop) ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            fail_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
            fail_q    <= fail_d;
            ovf_q     <= ovf_d;
        end
    end

    fsm_chk_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (LOG_W)
    ) u_log (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear_run),
        .push      (log_push),
        .push_data (log_entry),
        .pop       (log_pop),
        .head      (log_head),
        .full      (log_full),
        .empty     (log_empty)
    );

    assign mismatch  = fail_q;
    assign vec_cnt   = vec_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign done      = (state_q == ST_DONE) || (state_q == ST_HALT);
    assign pass      = (state_q == ST_DONE) && (err_cnt_q == '0);
    assign log_valid = !log_empty;
    assign log_data  = log_valid ? log_head : '0;
    assign log_ovf   = ovf_q;

endmodule

// File: tb/tb_fsm_vector_checker.sv
// Directed bench for fsm_vector_checker (default parameters); the halt scenario
// runs only when FSM_CHK_STOP_ON_ERR_EN is defined.
module tb_fsm_vector_checker;

    logic        clk, reset, start, vec_valid, vec_ready, mismatch;
    logic        done, pass, log_rd, log_valid, log_ovf;
    logic [2:0]  vin, cs;
    logic [3:0]  exp_out, dut_out;
    logic [15:0] vec_cnt, log_data;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    fsm_vector_checker #(.NUM_VECTORS(25), .LOG_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .in(vin), .cs(cs), .exp_out(exp_out),
        .dut_out(dut_out), .mismatch(mismatch), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .done(done), .pass(pass), .log_rd(log_rd),
        .log_valid(log_valid), .log_data(log_data), .log_ovf(log_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [2:0] i, input logic [2:0] c,
                            input logic [3:0] e, input logic [3:0] d);
        vec_valid = 1'b1; vin = i; cs = c; exp_out = e; dut_out = d;
        tick();
        vec_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; vec_valid = 1'b0; log_rd = 1'b0;
        vin = '0; cs = '0; exp_out = '0; dut_out = '0;
        #1;
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL rst_vec_ready got %b want 0", vec_ready); end
        checks++; if (vec_cnt !== 16'd0) begin errors++; $display("FAIL rst_vec_cnt got %0d want 0", vec_cnt); end
        checks++; if ({mismatch, done, pass, log_valid, log_ovf} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {mismatch, done, pass, log_valid, log_ovf}); end
        checks++; if (log_data !== 16'h0) begin errors++; $display("FAIL rst_log_data got %h want 0000", log_data); end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        tick();
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL idle_vec_ready got %b want 0", vec_ready); end
    endtask

    task automatic test_all_pass();
        start_run();
        checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL run_vec_ready got %b want 1", vec_ready); end
        checks++; if (vec_cnt !== 16'd0) begin errors++; $display("FAIL run_vec_cnt got %0d want 0", vec_cnt); end
        for (int k = 0; k < 25; k++) begin
            send_vec(3'(k % 5), 3'(k / 5), 4'(k), 4'(k));
            checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL pass_mismatch v%0d got %b want 0", k, mismatch); end
            if (k == 23) begin
                checks++; if (vec_cnt !== 16'd24) begin errors++; $display("FAIL pass_cnt24 got %0d want 24", vec_cnt); end
                checks++; if ({done, vec_ready} !== 2'b01) begin errors++; $display("FAIL pass_not_done got %b want 01", {done, vec_ready}); end
            end
        end
        checks++; if (vec_cnt !== 16'd25) begin errors++; $display("FAIL pass_vec_cnt got %0d want 25", vec_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL pass_err_cnt got %0d want 0", err_cnt); end
        checks++; if ({done, pass, log_valid, vec_ready} !== 4'b1100) begin errors++; $display("FAIL pass_done got %b want 1100", {done, pass, log_valid, vec_ready}); end
    endtask

    task automatic test_single_mismatch();
        start_run();
        checks++; if ({vec_cnt, done, pass} !== 18'd0) begin errors++; $display("FAIL restart_clear got %h want 0", {vec_cnt, done, pass}); end
        for (int k = 0; k < 25; k++) begin
            if (k == 7) send_vec(3'd1, 3'd2, 4'h3, 4'h5);
            else        send_vec(3'(k % 5), 3'(k / 5), 4'(k), 4'(k));
            checks++; if (mismatch !== (k == 7)) begin errors++; $display("FAIL mm_pulse v%0d got %b want %b", k, mismatch, (k == 7)); end
            if (k == 7) begin
                checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mm_err_cnt got %0d want 1", err_cnt); end
                checks++; if (log_data !== 16'h0735) begin errors++; $display("FAIL mm_log_data got %h want 0735", log_data); end
            end
        end
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL mm_done_pass got %b want 10", {done, pass}); end
        checks++; if ({log_valid, log_data} !== {1'b1, 16'h0735}) begin errors++; $display("FAIL mm_log_held got %b/%h want 1/0735", log_valid, log_data); end
        log_rd = 1'b1; tick(); log_rd = 1'b0;
        checks++; if ({log_valid, log_data} !== 17'h0) begin errors++; $display("FAIL pop_empty got %b/%h want 0/0000", log_valid, log_data); end
        log_rd = 1'b1; tick(); log_rd = 1'b0;
        checks++; if ({log_valid, log_ovf} !== 2'b00) begin errors++; $display("FAIL pop_on_empty got %b want 00", {log_valid, log_ovf}); end
    endtask

    task automatic test_overflow();
        start_run();
        for (int k = 0; k < 6; k++) begin
            send_vec(3'd0, 3'd0, 4'h1, 4'h2);
            if (k == 3) begin checks++; if (log_ovf !== 1'b0) begin errors++; $display("FAIL ovf_at_full got %b want 0", log_ovf); end end
            if (k == 4) begin checks++; if (log_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", log_ovf); end end
        end
        checks++; if (err_cnt !== 8'd6) begin errors++; $display("FAIL ovf_err_cnt got %0d want 6", err_cnt); end
        checks++; if ({log_valid, log_data} !== {1'b1, 16'h0012}) begin errors++; $display("FAIL ovf_head got %b/%h want 1/0012", log_valid, log_data); end
        for (int k = 6; k < 25; k++) send_vec(3'd0, 3'd0, 4'h0, 4'h0);
        checks++; if ({done, pass, log_ovf} !== 3'b101) begin errors++; $display("FAIL ovf_end got %b want 101", {done, pass, log_ovf}); end
    endtask

    task automatic test_push_pop_full();
        start_run();
        checks++; if ({log_valid, log_ovf, err_cnt} !== 10'd0) begin errors++; $display("FAIL flush got %b/%b/%0d want 0/0/0", log_valid, log_ovf, err_cnt); end
        for (int k = 0; k < 4; k++) send_vec(3'd0, 3'd0, 4'h1, 4'h2);
        log_rd = 1'b1;
        send_vec(3'd0, 3'd0, 4'h1, 4'h2);
        log_rd = 1'b0;
        checks++; if (log_ovf !== 1'b0) begin errors++; $display("FAIL pushpop_ovf got %b want 0", log_ovf); end
        checks++; if (err_cnt !== 8'd5) begin errors++; $display("FAIL pushpop_err_cnt got %0d want 5", err_cnt); end
        for (int j = 0; j < 4; j++) begin
            logic [15:0] want;
            want = {8'(j + 1), 8'h12};
            checks++; if (log_data !== want) begin errors++; $display("FAIL drain%0d got %h want %h", j, log_data, want); end
            log_rd = 1'b1; tick(); log_rd = 1'b0;
        end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", log_valid); end
        for (int k = 5; k < 25; k++) send_vec(3'd0, 3'd0, 4'h0, 4'h0);
        checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL pushpop_end got %b want 10", {done, pass}); end
    endtask

    task automatic test_illegal_state();
        start_run();
        send_vec(3'd0, 3'd6, 4'hA, 4'hA);
        checks++; if ({mismatch, err_cnt} !== {1'b1, 8'd1}) begin errors++; $display("FAIL cs6 got %b/%0d want 1/1", mismatch, err_cnt); end
        checks++; if (log_data !== 16'h00AA) begin errors++; $display("FAIL cs6_log got %h want 00aa", log_data); end
        checks++; if (vec_ready !== 1'b1) begin errors++; $display("FAIL cs6_continue got %b want 1", vec_ready); end
        send_vec(3'd5, 3'd0, 4'hA, 4'hA);
        checks++; if ({mismatch, err_cnt} !== {1'b1, 8'd2}) begin errors++; $display("FAIL in5 got %b/%0d want 1/2", mismatch, err_cnt); end
        send_vec(3'd4, 3'd4, 4'hB, 4'hB);
        checks++; if ({mismatch, err_cnt} !== {1'b0, 8'd2}) begin errors++; $display("FAIL legal44 got %b/%0d want 0/2", mismatch, err_cnt); end
        for (int k = 3; k < 10; k++) send_vec(3'd0, 3'd0, 4'h0, 4'h0);
        checks++; if (vec_cnt !== 16'd10) begin errors++; $display("FAIL cnt10 got %0d want 10", vec_cnt); end
    endtask

    task automatic test_reset_midrun();
        #2 reset = 1'b0;
        #1;
        checks++; if ({vec_cnt, err_cnt} !== 24'd0) begin errors++; $display("FAIL async_cnts got %0d/%0d want 0/0", vec_cnt, err_cnt); end
        checks++; if ({vec_ready, mismatch, done, pass, log_valid, log_ovf, log_data} !== 22'd0) begin errors++; $display("FAIL async_outs got %b/%h want 0", {vec_ready, mismatch, done, pass, log_valid, log_ovf}, log_data); end
        start = 1'b1;
        @(posedge clk);
        @(negedge clk) begin reset = 1'b1; start = 1'b0; end
        tick();
        checks++; if (vec_ready !== 1'b0) begin errors++; $display("FAIL post_rst_idle got %b want 0", vec_ready); end
        start = 1'b1; vec_valid = 1'b1; vin = '0; cs = '0; exp_out = '0; dut_out = '0;
        tick();
        start = 1'b0;
        checks++; if ({vec_ready, vec_cnt} !== {1'b1, 16'd0}) begin errors++; $display("FAIL no_accept_on_start got %b/%0d want 1/0", vec_ready, vec_cnt); end
        send_vec(3'd0, 3'd0, 4'h0, 4'h0);
        checks++; if (vec_cnt !== 16'd1) begin errors++; $display("FAIL first_accept got %0d want 1", vec_cnt); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if ({vec_ready, vec_cnt} !== {1'b1, 16'd1}) begin errors++; $display("FAIL start_in_run got %b/%0d want 1/1", vec_ready, vec_cnt); end
        for (int k = 1; k < 25; k++) send_vec(3'd2, 3'd1, 4'h6, 4'h6);
        checks++; if ({vec_cnt, done, pass} !== {16'd25, 2'b11}) begin errors++; $display("FAIL rerun_end got %0d/%b want 25/11", vec_cnt, {done, pass}); end
    endtask

`ifdef FSM_CHK_STOP_ON_ERR_EN
    task automatic test_halt();
        start_run();
        send_vec(3'd0, 3'd0, 4'h1, 4'h1);
        send_vec(3'd1, 3'd0, 4'h2, 4'h2);
        send_vec(3'd2, 3'd0, 4'h1, 4'h2);
        checks++; if ({mismatch, vec_ready, done, pass} !== 4'b1010) begin errors++; $display("FAIL halt_flags got %b want 1010", {mismatch, vec_ready, done, pass}); end
        checks++; if (vec_cnt !== 16'd3) begin errors++; $display("FAIL halt_cnt got %0d want 3", vec_cnt); end
        start = 1'b1; vec_valid = 1'b1; tick(); start = 1'b0; vec_valid = 1'b0;
        tick();
        checks++; if ({vec_ready, done, vec_cnt} !== {2'b01, 16'd3}) begin errors++; $display("FAIL halt_sticky got %b/%0d want 01/3", {vec_ready, done}, vec_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_all_pass();
`ifdef FSM_CHK_STOP_ON_ERR_EN
        test_halt();
`else
        test_single_mismatch();
        test_overflow();
        test_push_pop_full();
        test_illegal_state();
        test_reset_midrun();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
